// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with Moore pulse output and saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b011,
  parameter int OVERLAP = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  localparam int FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d, y_q, match;
  logic [PAT_W-1:0] win;
  // win is the candidate pattern; its low bits double as the shifted history
  always_comb begin
    win    = {hist_q, x};
    match  = en && fill_q == FULL && win == PATTERN;
    hist_d = en ? win[PAT_W-2:0] : hist_q;
    fill_d = !en ? fill_q : (match && OVERLAP == 0) ? '0 : (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    cnt_d  = cnt_clr ? '0 : (match && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    sat_d  = cnt_clr ? 1'b0 : sat_q | (match & (&cnt_q));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      y_q    <= match;
    end
  end
  assign y         = y_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table-driven and directed checks of four detector configurations.
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_a = 1'b0, x_a = 1'b0, clr_a = 1'b0;
  logic en_b = 1'b0, x_b = 1'b0;
  logic zero = 1'b0;
  logic y_a, y_s, y_o, y_n;
  logic sat_a, sat_s, sat_o, sat_n;
  logic [7:0] cnt_a, cnt_o, cnt_n;
  logic [1:0] cnt_s;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_detector_param dut_a (.clk(clk), .reset(reset), .en(en_a), .x(x_a), .cnt_clr(clr_a),
    .y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a));
  seq_detector_param #(.CNT_W(2)) dut_s (.clk(clk), .reset(reset), .en(en_a), .x(x_a), .cnt_clr(clr_a),
    .y(y_s), .match_cnt(cnt_s), .cnt_sat(sat_s));
  seq_detector_param #(.PATTERN(3'b101)) dut_o (.clk(clk), .reset(reset), .en(en_b), .x(x_b), .cnt_clr(zero),
    .y(y_o), .match_cnt(cnt_o), .cnt_sat(sat_o));
  seq_detector_param #(.PATTERN(3'b101), .OVERLAP(0)) dut_n (.clk(clk), .reset(reset), .en(en_b), .x(x_b),
    .cnt_clr(zero), .y(y_n), .match_cnt(cnt_n), .cnt_sat(sat_n));

  typedef struct {
    logic en;
    logic x;
    logic clr;
    logic y0;
    int   c0;
    logic y1;
    int   c1;
  } vec_t;

  vec_t va[12];
  vec_t vb[7];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic e, input logic xv, input logic c);
    @(negedge clk);
    en_a = e; x_a = xv; clr_a = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic e, input logic xv);
    @(negedge clk);
    en_b = e; x_b = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en_a = 0; en_b = 0; clr_a = 0; reset = 1;
    #1;
    chk("rst_y_a", y_a, 0); chk("rst_cnt_a", cnt_a, 0); chk("rst_sat_s", sat_s, 0);
    chk("rst_y_o", y_o, 0); chk("rst_cnt_n", cnt_n, 0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    va[0]  = '{1, 0, 0, 0, 0, 0, 0};
    va[1]  = '{1, 1, 0, 0, 0, 0, 0};
    va[2]  = '{1, 1, 0, 1, 1, 1, 1};
    va[3]  = '{0, 0, 0, 0, 1, 0, 1};
    va[4]  = '{1, 0, 0, 0, 1, 0, 1};
    va[5]  = '{0, 1, 0, 0, 1, 0, 1};
    va[6]  = '{0, 1, 0, 0, 1, 0, 1};
    va[7]  = '{0, 1, 0, 0, 1, 0, 1};
    va[8]  = '{1, 1, 0, 0, 1, 0, 1};
    va[9]  = '{1, 1, 0, 1, 2, 1, 2};
    va[10] = '{1, 1, 1, 0, 0, 0, 0};
    va[11] = '{1, 0, 0, 0, 0, 0, 0};
    // 101: overlapping (y0/c0) vs non-overlapping (y1/c1)
    vb[0] = '{1, 1, 0, 0, 0, 0, 0};
    vb[1] = '{1, 0, 0, 0, 0, 0, 0};
    vb[2] = '{1, 1, 0, 1, 1, 1, 1};
    vb[3] = '{1, 0, 0, 0, 1, 0, 1};
    vb[4] = '{1, 1, 0, 1, 2, 0, 1};
    vb[5] = '{1, 0, 0, 0, 2, 0, 1};
    vb[6] = '{1, 1, 0, 1, 3, 1, 2};

    do_reset();
    foreach (va[i]) begin
      drive_a(va[i].en, va[i].x, va[i].clr);
      chk($sformatf("a_y[%0d]", i), y_a, va[i].y0);
      chk($sformatf("a_cnt[%0d]", i), cnt_a, va[i].c0);
      chk($sformatf("s_y[%0d]", i), y_s, va[i].y1);
      chk($sformatf("s_cnt[%0d]", i), cnt_s, va[i].c1);
    end

    do_reset();
    foreach (vb[i]) begin
      drive_b(vb[i].en, vb[i].x);
      chk($sformatf("ov_y[%0d]", i), y_o, vb[i].y0);
      chk($sformatf("ov_cnt[%0d]", i), cnt_o, vb[i].c0);
      chk($sformatf("no_y[%0d]", i), y_n, vb[i].y1);
      chk($sformatf("no_cnt[%0d]", i), cnt_n, vb[i].c1);
    end
    drive_b(0, 1);
    chk("b_en0_y", y_o, 0);

    // saturation of the 2-bit counter, then clear coincident with a match
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive_a(1, 0, 0);
      drive_a(1, 1, 0);
      drive_a(1, 1, 0);
      chk($sformatf("sat_y[%0d]", k), y_s, 1);
      chk($sformatf("sat_cnt[%0d]", k), cnt_s, (k > 3) ? 3 : k);
      chk($sformatf("sat_flag[%0d]", k), sat_s, (k > 3) ? 1 : 0);
      chk($sformatf("wide_cnt[%0d]", k), cnt_a, k);
    end
    drive_a(1, 0, 0);
    drive_a(1, 1, 0);
    drive_a(1, 1, 1);
    chk("clr_y", y_s, 1);
    chk("clr_cnt", cnt_s, 0);
    chk("clr_sat", sat_s, 0);
    chk("clr_cnt_a", cnt_a, 0);
    drive_a(1, 0, 0);
    chk("clr_y_drop", y_s, 0);

    // asynchronous reset mid-pattern
    do_reset();
    drive_a(1, 0, 0);
    drive_a(1, 1, 0);
    drive_a(1, 1, 0);
    chk("pre_y", y_a, 1);
    drive_a(1, 0, 0);
    drive_a(1, 1, 0);
    chk("mid_y", y_a, 0);
    chk("mid_cnt", cnt_a, 1);
    #2 reset = 1;
    #1;
    chk("async_cnt", cnt_a, 0);
    @(negedge clk);
    reset = 0;
    drive_a(1, 1, 0);
    chk("post_y0", y_a, 0);
    drive_a(1, 0, 0);
    chk("post_y1", y_a, 0);
    drive_a(1, 1, 0);
    chk("post_y2", y_a, 0);
    drive_a(1, 1, 0);
    chk("post_y3", y_a, 1);
    chk("post_cnt", cnt_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 3, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 3'b011, bit sequence to detect; bit [PAT_W-1] is the first bit received, bit [0] the last.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1, serial bit-valid qualifier; x is sampled only when en=1.
REQ-008 SHALL have port x, input, 1, serial data bit.
REQ-009 SHALL have port cnt_clr, input, 1, synchronous clear of match_cnt and cnt_sat.
REQ-010 SHALL have port y, output, 1, registered (Moore) detect pulse.
REQ-011 SHALL have port match_cnt, output, CNT_W, number of matches since reset or the last clear.
REQ-012 SHALL have port cnt_sat, output, 1, sticky flag set when match_cnt saturates.

Function
REQ-013 SHALL keep a history register hist[PAT_W-2:0] of the most recent accepted bits, plus a fill counter of range 0..PAT_W-1.
REQ-014 SHALL update hist on an edge with en=1 as hist <= {hist[PAT_W-3:0], x}; for PAT_W=2, hist <= x.
REQ-015 SHALL increment fill on each accepted bit, saturating at PAT_W-1.
REQ-016 SHALL assert the internal match when en=1, fill=PAT_W-1 and {hist, x} equals PATTERN.
REQ-017 SHALL register y <= match on every edge, so y is high for exactly one cycle, in the cycle after the final pattern bit is sampled.
REQ-018 SHALL, on a match with OVERLAP=1, leave fill at PAT_W-1 so that a pattern suffix may begin the next match.
REQ-019 SHALL, on a match with OVERLAP=0, load fill to 0 so that the matching bits cannot contribute to a later match.
REQ-020 SHALL hold hist and fill unchanged on an edge with en=0; y goes to 0 on that edge.
REQ-021 SHALL increment match_cnt by 1 on each match edge, saturating at 2^CNT_W-1.
REQ-022 SHALL set cnt_sat on the edge where match_cnt would exceed 2^CNT_W-1; cnt_sat remains set until a clear or reset.
REQ-023 SHALL clear match_cnt and cnt_sat on an edge with cnt_clr=1; cnt_clr has priority over a simultaneous match.
REQ-024 SHALL leave y and detection state unaffected by cnt_clr: y still pulses for a match coincident with a clear.
REQ-025 SHALL have no combinational path from any input to any output.

Reset
REQ-026 SHALL, while reset=1, force hist=0, fill=0, y=0, match_cnt=0 and cnt_sat=0 immediately, independent of clk.
REQ-027 SHALL, on reset asserted mid-pattern, discard all partial history; a match then requires PAT_W fresh accepted bits after reset deasserts.

Verification
REQ-028 SHALL verify the defaults (PATTERN=011): reset, then x=0,1,1 with en=1 -> y=1 for exactly one cycle, in the cycle after the third bit; match_cnt=1.
REQ-029 SHALL verify PATTERN=101 with OVERLAP=1: x=1,0,1,0,1 -> two y pulses, after bit 3 and after bit 5; match_cnt=2. With OVERLAP=0, the same stimulus -> one pulse, after bit 3; match_cnt=1.
REQ-030 SHALL verify en gaps: x=0,(en=0 for 3 cycles),1,1 -> y pulses once after the last 1; y=0 during the en=0 cycles.
REQ-031 SHALL verify saturation with CNT_W=2: 5 matches -> match_cnt=3 and cnt_sat=1; cnt_clr coincident with a 6th match -> match_cnt=0, cnt_sat=0, y=1.
REQ-032 SHALL verify reset mid-operation: x=0,1, then async reset pulse, then x=1 -> no y pulse; then x=0,1,1 -> y pulse.
